cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Parametrised multicycle control sequencer for the CPU core. Owns the PC, instruction register and state machine.
- Adds an instruction-fetch valid/ready handshake, data-memory wait states, absolute branches, HALT, and a retired-instruction counter.
- Drives the decoded instruction fields to the register file, ALU and memory controller, and sequences their enables.

Parameters:
- PC_WIDTH, 8, program counter / instruction address width.
- INSTR_WIDTH, 32, instruction width; must be >= 32.
- RESET_PC, 0, PC value after reset.
- CNT_WIDTH, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_WIDTH  fetch address (= pc).
- imem_valid  in  1  fetch data valid.
- imem_rdata  in  INSTR_WIDTH  fetched instruction.
- condition_met  in  1  ALU flag-condition result for the current cond field (combinational).
- dmem_done  in  1  memory controller completed LDR/STR.
- cond  out  4  instr[31:28].
- opcode  out  4  instr[27:24].
- s  out  1  instr[23].
- dest  out  4  instr[22:19].
- src1  out  4  instr[18:15].
- src2  out  4  instr[14:11].
- shamt  out  5  instr[10:6].
- shctl  out  3  instr[2:0].
- immediate  out  16  instr[18:3].
- exec_en  out  1  one-cycle pulse: ALU/regfile commit.
- dmem_en  out  1  held high while a memory op is outstanding.
- pc  out  PC_WIDTH  current PC.
- halted  out  1  sequencer in HALT.
- instret  out  CNT_WIDTH  retired instruction count.

Behaviour:
- Reset (rst=0, async):
  - state=LOAD, pc=RESET_PC, instr register=0, instret=0.
  - All strobes 0: imem_req, exec_en, dmem_en, halted.
  - Field outputs are 0.
- States: LOAD, FETCH, DECODE, EXECUTE, MEMWAIT, HALT. Encoding is in the package.
- LOAD: goes to FETCH after 1 cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Stays in FETCH until imem_valid=1. On that edge, instr<=imem_rdata and the state goes to DECODE.
  - imem_valid outside FETCH is ignored.
- DECODE:
  - If cond!=0 and condition_met=0: the instruction is skipped. pc<=pc+1, state goes to FETCH, instret is unchanged.
  - Otherwise the state goes to EXECUTE.
  - All field outputs are driven from the registered instr at all times.
- EXECUTE (exactly 1 cycle, exec_en=1). Next state by opcode:
  - OP_HALT: state goes to HALT. pc is unchanged; instret+1.
  - OP_B: pc<=immediate[PC_WIDTH-1:0] (absolute; upper immediate bits are ignored). State goes to FETCH; instret+1.
  - OP_LDR/OP_STR: dmem_en<=1 and state goes to MEMWAIT.
  - Any other opcode: pc<=pc+1, state goes to FETCH, instret+1.
- MEMWAIT:
  - dmem_en=1 and exec_en=0 while waiting.
  - On dmem_done=1: pc<=pc+1, instret+1, dmem_en<=0, state goes to FETCH.
  - dmem_done may already be 1 in the first MEMWAIT cycle, giving a 1-cycle wait. There is no timeout.
- HALT: halted=1 and the sequencer stays there until reset. All request strobes are 0.
- Arithmetic:
  - PC increment wraps modulo 2^PC_WIDTH, so max PC+1 becomes 0.
  - instret wraps modulo 2^CNT_WIDTH.
- Latency: a non-memory, non-skipped instruction takes FETCH(>=1) + DECODE(1) + EXECUTE(1) cycles, minimum 3. A skipped instruction takes minimum 2.
- Reset mid-operation: an asserted reset aborts any state immediately, including outstanding FETCH and MEMWAIT. The external memory is expected to drop its pending handshake when imem_req/dmem_en go low.
- Simultaneous events: dmem_done and imem_valid are only sampled in their own states.

Decomposition:
- Package cpu_pkg holds:
  - State encoding: LOAD=0, FETCH=1, DECODE=2, EXECUTE=3, MEMWAIT=4, HALT=5.
  - Opcode constants: OP_LDR=4'b1100, OP_STR=4'b1101, OP_B=4'b1110, OP_HALT=4'b1111.
  - Instruction field bit positions.
- One natural sub-module: instr_field_decode. It is combinational and slices the registered instruction into the field outputs.

Test Plan:
- Reset, then ADD (opcode 0, cond 0) at pc 0 with imem_valid the cycle after req -> exec_en pulses once, pc=1, instret=1, 3 cycles total.
- Fetch stall: imem_valid held low for 4 cycles -> imem_req stays high, imem_addr stays constant, state stays FETCH, no exec_en.
- cond=4'b0001 with condition_met=0 -> no exec_en, pc+1, instret unchanged.
- LDR with dmem_done asserted after 3 MEMWAIT cycles -> dmem_en high 3 cycles, then pc+1, instret+1. STR with immediate done -> 1 MEMWAIT cycle.
- OP_B with immediate=16'h00F3, PC_WIDTH=8 -> next imem_addr=8'hF3. Separately, pc=8'hFF with a normal op -> pc wraps to 0.
- OP_HALT -> halted=1 and the sequencer stays there 20 cycles with no imem_req. Async rst pulsed mid-MEMWAIT -> immediate return to reset values, then a clean restart at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU sequencer:
// state encoding, opcodes and instruction field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEMWAIT = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDR  = 4'b1100;
    localparam logic [3:0] OP_STR  = 4'b1101;
    localparam logic [3:0] OP_B    = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int COND_LSB  = 28;
    localparam int OPC_LSB   = 24;
    localparam int S_BIT     = 23;
    localparam int DEST_LSB  = 19;
    localparam int SRC1_LSB  = 15;
    localparam int SRC2_LSB  = 11;
    localparam int SHAMT_LSB = 6;
    localparam int IMM_LSB   = 3;
    localparam int SHCTL_LSB = 0;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/cpu_sequencer_instr_field_decode.sv
// Combinational slicing of the registered instruction
// into the operand/control fields seen by the datapath.
module instr_field_decode
    import cpu_pkg::*;
#(
    parameter int INSTR_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic [3:0]             cond,
    output logic [3:0]             opcode,
    output logic                   s,
    output logic [3:0]             dest,
    output logic [3:0]             src1,
    output logic [3:0]             src2,
    output logic [4:0]             shamt,
    output logic [2:0]             shctl,
    output logic [15:0]            immediate
);

    assign cond      = instr[COND_LSB +: 4];
    assign opcode    = instr[OPC_LSB +: 4];
    assign s         = instr[S_BIT];
    assign dest      = instr[DEST_LSB +: 4];
    assign src1      = instr[SRC1_LSB +: 4];
    assign src2      = instr[SRC2_LSB +: 4];
    assign shamt     = instr[SHAMT_LSB +: 5];
    assign shctl     = instr[SHCTL_LSB +: 3];
    assign immediate = instr[IMM_LSB +: 16];

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control sequencer: owns PC, instruction register,
// fetch/memory handshakes and the retired-instruction counter.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   condition_met,
    input  logic                   dmem_done,
    output logic [3:0]             cond,
    output logic [3:0]             opcode,
    output logic                   s,
    output logic [3:0]             dest,
    output logic [3:0]             src1,
    output logic [3:0]             src2,
    output logic [4:0]             shamt,
    output logic [2:0]             shctl,
    output logic [15:0]            immediate,
    output logic                   exec_en,
    output logic                   dmem_en,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   instret
);

    state_t                 state;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc_inc;
    logic [PC_WIDTH-1:0]    pc_target;
    logic [CNT_WIDTH-1:0]   instret_inc;
    logic                   skip;
    logic                   is_halt;
    logic                   is_branch;
    logic                   is_mem;

    instr_field_decode #(
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_decode (
        .instr    (instr),
        .cond     (cond),
        .opcode   (opcode),
        .s        (s),
        .dest     (dest),
        .src1     (src1),
        .src2     (src2),
        .shamt    (shamt),
        .shctl    (shctl),
        .immediate(immediate)
    );

    assign imem_addr   = pc;
    assign pc_inc      = pc + PC_WIDTH'(1);
    assign instret_inc = instret + CNT_WIDTH'(1);
    // Branch target is absolute; bits above PC_WIDTH are dropped.
    assign pc_target   = PC_WIDTH'(immediate);
    assign skip        = (cond != 4'd0) && !condition_met;
    assign is_halt     = (opcode == OP_HALT);
    assign is_branch   = (opcode == OP_B);
    assign is_mem      = is_mem_op(opcode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_LOAD;
            pc       <= RESET_PC;
            instr    <= '0;
            instret  <= '0;
            imem_req <= 1'b0;
            exec_en  <= 1'b0;
            dmem_en  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (skip) begin
                        pc       <= pc_inc;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        exec_en <= 1'b1;
                        state   <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    exec_en <= 1'b0;
                    unique case (1'b1)
                        is_halt: begin
                            halted  <= 1'b1;
                            instret <= instret_inc;
                            state   <= S_HALT;
                        end
                        is_branch: begin
                            pc       <= pc_target;
                            instret  <= instret_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        is_mem: begin
                            dmem_en <= 1'b1;
                            state   <= S_MEMWAIT;
                        end
                        default: begin
                            pc       <= pc_inc;
                            instret  <= instret_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    endcase
                end
                S_MEMWAIT: begin
                    if (dmem_done) begin
                        dmem_en  <= 1'b0;
                        pc       <= pc_inc;
                        instret  <= instret_inc;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
